// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle MULT/DIV controller owning HI/LO for the E stage.
// Optional MDU_DIVZERO_KEEP_EN: divide-by-zero leaves HI/LO untouched, no busy.
module mdu_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  md_op_E,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    input  logic        md_class_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [63:0] r_result;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_is_mul;
    logic        w_is_div;
    logic        w_div_go;
    logic        w_dsigned;
    logic        w_rt_zero;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_mag_b_nz;
    logic [31:0] w_q_u;
    logic [31:0] w_r_u;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic [63:0] w_div_res;

    assign w_is_mul  = (md_op_E == OP_MULT) || (md_op_E == OP_MULTU);
    assign w_is_div  = (md_op_E == OP_DIV) || (md_op_E == OP_DIVU);
    assign w_dsigned = (md_op_E == OP_DIV);
    assign w_rt_zero = (rt_E == 32'd0);

`ifdef MDU_DIVZERO_KEEP_EN
    assign w_div_go = w_is_div && !w_rt_zero;
`else
    assign w_div_go = w_is_div;
`endif

    // Sign-extended operands give the signed product in the low 64 bits.
    assign w_prod_s = {{32{rs_E[31]}}, rs_E} * {{32{rt_E[31]}}, rt_E};
    assign w_prod_u = {32'd0, rs_E} * {32'd0, rt_E};

    // Signed divide through magnitudes; 0x80000000 wraps back to itself.
    assign w_mag_a    = (w_dsigned && rs_E[31]) ? (~rs_E + 32'd1) : rs_E;
    assign w_mag_b    = (w_dsigned && rt_E[31]) ? (~rt_E + 32'd1) : rt_E;
    assign w_mag_b_nz = w_rt_zero ? 32'd1 : w_mag_b;
    assign w_q_u      = w_mag_a / w_mag_b_nz;
    assign w_r_u      = w_mag_a % w_mag_b_nz;
    assign w_q = (w_dsigned && (rs_E[31] ^ rt_E[31])) ? (~w_q_u + 32'd1) : w_q_u;
    assign w_r = (w_dsigned && rs_E[31]) ? (~w_r_u + 32'd1) : w_r_u;
    assign w_div_res = w_rt_zero ? {rs_E, 32'hFFFF_FFFF} : {w_r, w_q};

    // IDLE/BUSY sequencer: latches the result at start, commits it on the last edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_result <= 64'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_is_mul) begin
                        r_result <= (md_op_E == OP_MULT) ? w_prod_s : w_prod_u;
                        r_cnt    <= 4'(MULT_CYC);
                        r_state  <= S_BUSY;
                    end else if (w_div_go) begin
                        r_result <= w_div_res;
                        r_cnt    <= 4'(DIV_CYC);
                        r_state  <= S_BUSY;
                    end else if (md_op_E == OP_MTHI) begin
                        r_hi <= rs_E;
                    end else if (md_op_E == OP_MTLO) begin
                        r_lo <= rs_E;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        r_cnt   <= 4'd0;
                        r_hi    <= r_result[63:32];
                        r_lo    <= r_result[31:0];
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = (r_state == S_BUSY);
    assign stall_md = md_class_D && (busy || w_is_mul || w_is_div);
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed vectors for mdu_ctrl with hand-computed HI/LO,
// busy-window lengths and stall-window lengths.
module tb_mdu_ctrl;

    logic        clk;
    logic        reset_n;
    logic [2:0]  md_op_E;
    logic [31:0] rs_E;
    logic [31:0] rt_E;
    logic        md_class_D;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks;
    int n_fail;

    mdu_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .md_op_E    (md_op_E),
        .rs_E       (rs_E),
        .rt_E       (rt_E),
        .md_class_D (md_class_D),
        .busy       (busy),
        .stall_md   (stall_md),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op with md_class_D high and measure busy and stall windows.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int nbusy,
                          output int nstall);
        int g;
        md_op_E    = op;
        rs_E       = a;
        rt_E       = b;
        md_class_D = 1'b1;
        #1;
        nstall = stall_md ? 1 : 0;
        step();
        md_op_E = 3'd0;
        nbusy   = 0;
        g       = 0;
        while (busy && g < 40) begin
            nbusy++;
            if (stall_md) nstall++;
            step();
            g++;
        end
        md_class_D = 1'b0;
    endtask

    initial begin
        int nb;
        int ns;
        int bad;
        logic [31:0] hold_hi;
        logic [31:0] hold_lo;
        n_checks   = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        md_op_E    = 3'd0;
        rs_E       = 32'd0;
        rt_E       = 32'd0;
        md_class_D = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);

        run_op(3'd1, 32'hFFFF_FFFF, 32'h2, nb, ns);
        chk("mult_busy", 64'(nb), 64'd5);
        chk("mult_stall", 64'(ns), 64'd6);
        chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);

        run_op(3'd2, 32'hFFFF_FFFF, 32'h2, nb, ns);
        chk("multu_busy", 64'(nb), 64'd5);
        chk("multu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

        run_op(3'd3, 32'hFFFF_FFF9, 32'h2, nb, ns);
        chk("div_busy", 64'(nb), 64'd10);
        chk("div_stall", 64'(ns), 64'd11);
        chk("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        run_op(3'd3, 32'h0000_0007, 32'hFFFF_FFFE, nb, ns);
        chk("div_negb", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, nb, ns);
        chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);

        run_op(3'd4, 32'd100, 32'd7, nb, ns);
        chk("divu_busy", 64'(nb), 64'd10);
        chk("divu_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

        md_op_E = 3'd5;
        rs_E    = 32'h1234_5678;
        step();
        chk("mthi_hi", {32'd0, hi}, 64'h1234_5678);
        chk("mthi_busy", {63'd0, busy}, 64'd0);
        md_op_E = 3'd6;
        rs_E    = 32'h9ABC_DEF0;
        step();
        md_op_E = 3'd0;
        chk("mtlo_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
        chk("mtlo_busy", {63'd0, busy}, 64'd0);

        // Ops arriving while busy must be ignored; stall follows md_class_D.
        md_op_E = 3'd1;
        rs_E    = 32'd3;
        rt_E    = 32'd4;
        step();
        md_op_E    = 3'd5;
        rs_E       = 32'hDEAD_BEEF;
        md_class_D = 1'b0;
        #1;
        chk("busy_noclass_stall", {63'd0, stall_md}, 64'd0);
        step();
        md_op_E = 3'd0;
        chk("busy_ignore_op", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
        for (int i = 0; i < 8; i++) step();
        chk("mult_small", {hi, lo}, 64'h0000_0000_0000_000C);

        hold_hi = hi;
        hold_lo = lo;
        run_op(3'd4, 32'd7, 32'd0, nb, ns);
`ifdef MDU_DIVZERO_KEEP_EN
        chk("dz_busy", 64'(nb), 64'd0);
        chk("dz_stall", 64'(ns), 64'd1);
        chk("dz_hilo", {hi, lo}, {hold_hi, hold_lo});
`else
        chk("dz_busy", 64'(nb), 64'd10);
        chk("dz_stall", 64'(ns), 64'd11);
        chk("dz_hilo", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
`endif

        // Reset in busy cycle 4 discards the in-flight divide.
        md_op_E = 3'd3;
        rs_E    = 32'd100;
        rt_E    = 32'd7;
        step();
        md_op_E = 3'd0;
        step();
        step();
        step();
        chk("pre_rst_busy", {63'd0, busy}, 64'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_hilo", {hi, lo}, 64'd0);
        step();
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (busy || hi != 32'd0 || lo != 32'd0) bad++;
        end
        chk("post_rst_quiet", 64'(bad), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
